// File: rtl/poisson_spike_array.sv
// rtl/poisson_spike_array.sv - multi-channel Poisson spike source built on per-channel Fibonacci LFSRs
module poisson_spike_array #(
  parameter int          N        = 32,
  parameter int          CHANNELS = 4,
  parameter int          RATE_W   = 16,
  parameter int          REFRAC_W = 4,
  parameter logic [31:0] INIT     = 32'h6BCB769C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               seed,
  input  logic                       tick,
  input  logic [CHANNELS*RATE_W-1:0] rate,
  input  logic [REFRAC_W-1:0]        refrac,
  output logic [CHANNELS-1:0]        spike,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 drop_cnt,
  output logic [N-1:0]               rand0
);

  if (!(N == 16 || N == 24 || N == 32)) begin : g_bad_n
    $error("poisson_spike_array: N must be 16, 24 or 32");
  end
  if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
    $error("poisson_spike_array: CHANNELS must be 1..64");
  end
  if (RATE_W > N) begin : g_bad_rate_w
    $error("poisson_spike_array: RATE_W must not exceed N");
  end

  // Feedback taps expressed as a bit mask over the current state.
  localparam logic [31:0]  TAP_MASK = (N == 32) ? 32'h8020_0003 :
                                      (N == 24) ? 32'h00E1_0000 : 32'h0000_B400;
  localparam logic [N-1:0] TAPS     = TAP_MASK[N-1:0];
  localparam logic [N-1:0] INIT_N   = INIT[N-1:0];

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int k);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(i + k) % N] = x[i];
    return r;
  endfunction

  logic [N-1:0]        lfsr       [CHANNELS];
  logic [N-1:0]        lfsr_nxt   [CHANNELS];
  logic [N-1:0]        seed_state [CHANNELS];
  logic [REFRAC_W-1:0] ref_cnt    [CHANNELS];
  logic [CHANNELS-1:0] raw;
  logic                accept;
  logic                drop;

  always_comb begin
    accept = tick && (!out_valid || out_ready);
    drop   = tick && out_valid && !out_ready;
    raw    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lfsr_nxt[c] = {lfsr[c][N-2:0], ^(lfsr[c] & TAPS)};
      // The spike decision uses the top RATE_W bits of the advanced state.
      raw[c] = (&rate[c*RATE_W +: RATE_W]) ||
               (lfsr_nxt[c][N-1 -: RATE_W] < rate[c*RATE_W +: RATE_W]);
      seed_state[c] = rotl(INIT_N, c) ^ seed;
      if (seed_state[c] == '0) seed_state[c] = N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lfsr[c]    <= seed_state[c];
        ref_cnt[c] <= '0;
      end
      spike     <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (accept) begin
        for (int c = 0; c < CHANNELS; c++) begin
          lfsr[c] <= lfsr_nxt[c];
          if (ref_cnt[c] != '0) begin
            spike[c]   <= 1'b0;
            ref_cnt[c] <= ref_cnt[c] - REFRAC_W'(1);
          end else begin
            spike[c] <= raw[c];
            if (raw[c]) ref_cnt[c] <= refrac;
          end
        end
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign rand0 = lfsr[0];

endmodule
